inst_fetch_unit: RTL and testbench

- Sits between the Y86 CPU fetch port and a byte-wide instruction memory.
- On a fetch request at a PC, it reads bytes sequentially from memory and decodes the instruction length from the icode nibble of byte 0.
- It assembles the complete variable-length (1-6 byte) instruction and holds it to the CPU with a valid/ack handshake.
- It supports flush for redirects.

---
 rtl/inst_fetch_unit_pkg.sv | 58 +++++
 rtl/inst_fetch_unit_len_decode.sv | 20 ++
 rtl/inst_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, types and the icode length table for the Y86 instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int unsigned DEF_INST_BYTES = 6;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LEN_W          = 3;
  localparam int unsigned CNT_W          = 3;

  // Y86 icode values (upper nibble of instruction byte 0)
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  // Instruction lengths in bytes
  localparam logic [LEN_W-1:0] LEN_1 = 3'd1;
  localparam logic [LEN_W-1:0] LEN_2 = 3'd2;
  localparam logic [LEN_W-1:0] LEN_5 = 3'd5;
  localparam logic [LEN_W-1:0] LEN_6 = 3'd6;

  // Fetch FSM encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             err;
  } len_info_t;

  // Map an icode to its instruction length; unknown icodes report length 1 with err set.
  function automatic len_info_t decode_len(input logic [3:0] icode);
    len_info_t r;
    r.len = LEN_1;
    r.err = 1'b0;
    case (icode)
      IHALT, INOP, IRET:             r.len = LEN_1;
      IRRMOVL, IOPL, IPUSHL, IPOPL:  r.len = LEN_2;
      IJXX, ICALL:                   r.len = LEN_5;
      IIRMOVL, IRMMOVL, IMRMOVL:     r.len = LEN_6;
      default: begin
        r.len = LEN_1;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_len_decode.sv
// Combinational icode -> {length, error} decoder, shared with the CPU decode stage.
module inst_len_decode
  import inst_fetch_unit_pkg::*;
(
  input  logic [3:0]       icode_i,
  output logic [LEN_W-1:0] len_c,
  output logic             err_c
);

  len_info_t info_c;

  // Table lookup of the instruction length
  always_comb begin
    info_c = decode_len(icode_i);
  end

  assign len_c = info_c.len;
  assign err_c = info_c.err;

endmodule

// File: rtl/inst_fetch_unit.sv
// Y86 instruction fetch unit: reads a variable-length instruction byte by byte from a
// 1-cycle-latency byte memory and holds it to the CPU under a valid/ack handshake.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned INST_BYTES = DEF_INST_BYTES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_req_i,
  input  logic [ADDR_W-1:0]            pc_i,
  output logic                         fetch_ready_o,
  input  logic                         flush_i,
  output logic                         inst_valid_o,
  input  logic                         inst_ack_i,
  output logic [BYTE_W*INST_BYTES-1:0] inst_o,
  output logic [LEN_W-1:0]             inst_len_o,
  output logic                         inst_err_o,
  output logic                         mem_rd_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic [BYTE_W-1:0]            mem_data_i
);

  localparam int unsigned INST_W = BYTE_W * INST_BYTES;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic              rd_prev_q, rd_prev_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  dec_len_c;
  logic              dec_err_c;
  logic              accept_c;
  logic              capture_c;
  logic              last_c;
  logic [LEN_W-1:0]  cur_len_c;
  logic [CNT_W-1:0]  next_k_c;
  logic [CNT_W-1:0]  byte_pos_c;

  // Byte 0 is on mem_data_i when rcv_cnt is zero, so its length is decoded straight from the bus
  inst_len_decode u_len_decode (
    .icode_i (mem_data_i[7:4]),
    .len_c   (dec_len_c),
    .err_c   (dec_err_c)
  );

  // Ready to take a request when idle, or when the held instruction is being consumed
  assign fetch_ready_o = (state_q == ST_IDLE) |
                         ((state_q == ST_DONE) & inst_ack_i & ~flush_i);

  // Next-state, read issue and instruction assembly
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    rd_prev_d  = mem_rd_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    len_d      = len_q;
    err_d      = err_q;

    accept_c   = fetch_ready_o & fetch_req_i & ~flush_i;
    capture_c  = (state_q == ST_COLLECT) & rd_prev_q;
    cur_len_c  = (rcv_cnt_q == '0) ? dec_len_c : len_q;
    last_c     = capture_c & ((rcv_cnt_q + CNT_W'(1)) == cur_len_c);
    next_k_c   = iss_cnt_q + CNT_W'(1);
    byte_pos_c = CNT_W'(INST_BYTES - 1) - rcv_cnt_q;

    if (flush_i) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      rd_prev_d = 1'b0;
      inst_d    = '0;
      len_d     = '0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) state_d = ST_COLLECT;
        end
        ST_COLLECT: begin
          if (capture_c) begin
            inst_d    = inst_q | (INST_W'(mem_data_i) << (BYTE_W * byte_pos_c));
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
            if (rcv_cnt_q == '0) begin
              len_d = dec_len_c;
              err_d = dec_err_c;
            end
          end
          if (last_c) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else if (mem_rd_q && ((next_k_c == CNT_W'(1)) || (next_k_c < cur_len_c))) begin
            // Address pc+1 always goes out; later addresses only while inside the length
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q + ADDR_W'(next_k_c);
            iss_cnt_d  = next_k_c;
          end
        end
        ST_DONE: begin
          if (inst_ack_i) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = accept_c ? ST_COLLECT : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase

      if (accept_c) begin
        pc_d       = pc_i;
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_i;
        iss_cnt_d  = '0;
        rcv_cnt_d  = '0;
        rd_prev_d  = 1'b0;
        valid_d    = 1'b0;
        inst_d     = '0;
        len_d      = '0;
        err_d      = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      rd_prev_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      rd_prev_q  <= rd_prev_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_len_o   = len_q;
  assign inst_err_o   = err_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected reads and instructions,
// a negedge monitor pops and compares them as the DUT presents reads and valid instructions.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        fetch_ready_o;
  logic        flush_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ack_i = 1'b0;
  logic [47:0] inst_o;
  logic [2:0]  inst_len_o;
  logic        inst_err_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { logic [31:0] addr; int cyc; } rd_exp_t;
  typedef struct { logic [47:0] inst; logic [2:0] len; logic err; int cyc; } inst_exp_t;

  rd_exp_t   rdq[$];
  inst_exp_t iq[$];
  rd_exp_t   r;
  inst_exp_t cur;
  logic      vprev = 1'b0;
  logic      consumed_prev = 1'b0;

  logic [7:0] mem [logic [31:0]];

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req_i   (fetch_req_i),
    .pc_i          (pc_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ack_i    (inst_ack_i),
    .inst_o        (inst_o),
    .inst_len_o    (inst_len_o),
    .inst_err_o    (inst_err_o),
    .mem_rd_o      (mem_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory with one cycle of read latency; garbage when no read was issued
  always @(posedge clk) begin
    if (mem_rd_o && mem.exists(mem_addr_o)) mem_data_i <= mem[mem_addr_o];
    else mem_data_i <= 8'($urandom);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    if (ic == 4'h0 || ic == 4'h1 || ic == 4'h9) return 1;
    if (ic == 4'h2 || ic == 4'h6 || ic == 4'hA || ic == 4'hB) return 2;
    if (ic == 4'h7 || ic == 4'h8) return 5;
    if (ic >= 4'h3 && ic <= 4'h5) return 6;
    return 1;
  endfunction

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Expected reads and instruction for a request accepted in cycle t0
  task automatic push_expect(input logic [31:0] pc, input int t0);
    logic [7:0] b0;
    int l;
    int nrd;
    inst_exp_t e;
    b0  = rd_mem(pc);
    l   = ref_len(b0[7:4]);
    nrd = (l < 2) ? 2 : l;
    for (int k = 0; k < nrd; k++) rdq.push_back('{pc + 32'(k), t0 + 1 + k});
    e.inst = '0;
    for (int k = 0; k < l; k++) e.inst = e.inst | (48'(rd_mem(pc + 32'(k))) << (8 * (5 - k)));
    e.len = 3'(l);
    e.err = (b0[7:4] >= 4'hC);
    e.cyc = t0 + l + 2;
    iq.push_back(e);
  endtask

  task automatic load_bytes(input logic [31:0] pc, input logic [47:0] bytes);
    logic [47:0] b;
    b = bytes;
    for (int k = 0; k < 6; k++) mem[pc + 32'(k)] = b[47 - 8*k -: 8];
  endtask

  task automatic load_rand(input logic [31:0] pc);
    logic [7:0] b;
    for (int k = 1; k < 6; k++) mem[pc + 32'(k)] = 8'($urandom);
    b = 8'($urandom);
    b[7:4] = 4'($urandom_range(0, 15));
    mem[pc] = b;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
    return 32'($urandom);
  endfunction

  // Issue a request (optionally together with an ack of the held instruction)
  task automatic start_fetch(input logic [31:0] pc, input logic with_ack);
    fetch_req_i = 1'b1;
    pc_i        = pc;
    inst_ack_i  = with_ack;
    #1;
    chk("fetch_ready", 64'(fetch_ready_o), 64'd1);
    push_expect(pc, cyc);
    @(posedge clk); #1;
    fetch_req_i = 1'b0;
    inst_ack_i  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_valid_o) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: inst_valid_o=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic ack_only();
    inst_ack_i = 1'b1;
    @(posedge clk); #1;
    inst_ack_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop expected reads and instructions as the DUT presents them
  always @(negedge clk) begin
    if (rst) begin
      vprev         = 1'b0;
      consumed_prev = 1'b0;
    end else begin
      if (mem_rd_o) begin
        if (rdq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_read: addr %0h in cycle %0d, no read expected", mem_addr_o, cyc);
        end else begin
          r = rdq.pop_front();
          chk("rd_addr", 64'(mem_addr_o), 64'(r.addr));
          chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
      if (inst_valid_o) begin
        if (vprev && consumed_prev) begin
          checks++;
          failures++;
          $display("FAIL valid_after_ack: inst_valid_o=1 in cycle %0d, required 0", cyc);
        end else if (!vprev) begin
          if (iq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid: inst_o %0h in cycle %0d, none expected", inst_o, cyc);
          end else begin
            cur = iq.pop_front();
            chk("inst", 64'(inst_o), 64'(cur.inst));
            chk("len", 64'(inst_len_o), 64'(cur.len));
            chk("err", 64'(inst_err_o), 64'(cur.err));
            chk("valid_cycle", 64'(cyc), 64'(cur.cyc));
          end
        end else begin
          chk("hold_inst", 64'(inst_o), 64'(cur.inst));
          chk("hold_len", 64'(inst_len_o), 64'(cur.len));
          chk("hold_err", 64'(inst_err_o), 64'(cur.err));
        end
      end
      vprev         = inst_valid_o;
      consumed_prev = inst_valid_o & (inst_ack_i | flush_i);
    end
  end

  initial begin
    logic [31:0] next_pc;
    logic        armed;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_len", 64'(inst_len_o), 64'd0);
    chk("rst_err", 64'(inst_err_o), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_ready", 64'(fetch_ready_o), 64'd1);
    rst = 1'b0;
    step(1);

    // nop at 0x100, followed by irmovl at 0x0 held for 5 cycles, then back-to-back addl at 0x6
    load_bytes(32'h100, 48'h10_AB_CD_EF_01_23);
    load_bytes(32'h0,   48'h30_F0_04_03_02_01);
    load_bytes(32'h6,   48'h60_12_55_66_77_88);
    start_fetch(32'h100, 1'b0);
    wait_valid();
    ack_only();
    start_fetch(32'h0, 1'b0);
    wait_valid();
    step(5);
    chk("hold_mem_rd", 64'(mem_rd_o), 64'd0);
    start_fetch(32'h6, 1'b1);
    chk("b2b_addr", 64'(mem_addr_o), 64'h6);
    chk("b2b_rd", 64'(mem_rd_o), 64'd1);
    chk("b2b_valid_low", 64'(inst_valid_o), 64'd0);
    wait_valid();
    ack_only();

    // Flush in T4 of an irmovl fetch, then rrmovl at 0x20
    load_bytes(32'h40, 48'h30_F3_78_56_34_12);
    load_bytes(32'h20, 48'h20_12_99_99_99_99);
    start_fetch(32'h40, 1'b0);
    step(2);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    rdq.delete();
    iq.delete();
    chk("flush_mem_rd", 64'(mem_rd_o), 64'd0);
    chk("flush_valid", 64'(inst_valid_o), 64'd0);
    chk("flush_ready", 64'(fetch_ready_o), 64'd1);
    step(6);
    chk("flush_no_valid", 64'(inst_valid_o), 64'd0);
    start_fetch(32'h20, 1'b0);
    wait_valid();
    ack_only();

    // Invalid icode, then a nop that must report no error
    load_bytes(32'h80, 48'hF0_10_00_00_00_00);
    start_fetch(32'h80, 1'b0);
    wait_valid();
    ack_only();
    start_fetch(32'h81, 1'b0);
    wait_valid();
    ack_only();

    // jmp across the address wrap, then reset in T3 of the same fetch
    load_bytes(32'hFFFF_FFFD, 48'h70_44_33_22_11_00);
    start_fetch(32'hFFFF_FFFD, 1'b0);
    wait_valid();
    ack_only();
    start_fetch(32'hFFFF_FFFD, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rdq.delete();
    iq.delete();
    chk("mid_rst_valid", 64'(inst_valid_o), 64'd0);
    chk("mid_rst_inst", 64'(inst_o), 64'd0);
    chk("mid_rst_len", 64'(inst_len_o), 64'd0);
    chk("mid_rst_err", 64'(inst_err_o), 64'd0);
    chk("mid_rst_mem_rd", 64'(mem_rd_o), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr_o), 64'd0);
    step(8);
    chk("mid_rst_no_valid", 64'(inst_valid_o), 64'd0);

    // Randomized fetches with random hold times and back-to-back requests
    armed   = 1'b0;
    next_pc = rand_pc();
    load_rand(next_pc);
    for (int n = 0; n < 60; n++) begin
      if (!armed) start_fetch(next_pc, 1'b0);
      wait_valid();
      step($urandom_range(0, 3));
      next_pc = rand_pc();
      load_rand(next_pc);
      if (n != 59 && $urandom_range(0, 1) == 1) begin
        start_fetch(next_pc, 1'b1);
        armed = 1'b1;
      end else begin
        ack_only();
        armed = 1'b0;
      end
    end

    step(4);
    chk("reads_drained", 64'(rdq.size()), 64'd0);
    chk("insts_drained", 64'(iq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
